// File: rtl/systolic_array_is_seq.sv
// Input-stationary systolic matrix-vector engine: a grid of pe_is MACs holding A,
// weight skew / psum unskew registers, and a load/stream/drain sequencer with handshakes.

module pe_is #(
   parameter int INPUT_WIDTH  = 16,
   parameter int WEIGHT_WIDTH = 16,
   parameter int PSUM_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    input_en,
   input  logic [INPUT_WIDTH-1:0]  input_in,
   output logic [INPUT_WIDTH-1:0]  input_out,
   input  logic                    process_en,
   input  logic [WEIGHT_WIDTH-1:0] weight_in,
   input  logic [PSUM_WIDTH-1:0]   psum_in,
   output logic [WEIGHT_WIDTH-1:0] weight_out,
   output logic [PSUM_WIDTH-1:0]   psum_out
);

   // Signed multiply, sign-extend the product, accumulate modulo 2^PSUM_WIDTH.
   function automatic logic [PSUM_WIDTH-1:0] mac(input logic [PSUM_WIDTH-1:0]   acc,
                                                 input logic [INPUT_WIDTH-1:0]  a,
                                                 input logic [WEIGHT_WIDTH-1:0] w);
      logic signed [INPUT_WIDTH+WEIGHT_WIDTH-1:0] prod;
      prod = $signed(a) * $signed(w);
      return acc + PSUM_WIDTH'(prod);
   endfunction

   // Stationary input element, shifted in during LOAD only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         input_out <= '0;
      end else if (input_en) begin
         input_out <= input_in;
      end else begin
         input_out <= input_out;
      end
   end

   // Weight passes down, partial sum passes right.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_out <= '0;
         psum_out   <= '0;
      end else if (process_en) begin
         weight_out <= weight_in;
         psum_out   <= mac(psum_in, input_out, weight_in);
      end else begin
         weight_out <= weight_out;
         psum_out   <= psum_out;
      end
   end

endmodule

module systolic_array_is_seq #(
   parameter int INPUT_WIDTH  = 16,
   parameter int WEIGHT_WIDTH = 16,
   parameter int PSUM_WIDTH   = 32,
   parameter int ARRAY_HEIGHT = 4,
   parameter int ARRAY_WIDTH  = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [CNT_WIDTH-1:0]                 cfg_num_vecs,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0]  in_data,
   input  logic                                 w_valid,
   output logic                                 w_ready,
   input  logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0]  w_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]   out_data,
   output logic                                 busy,
   output logic                                 done
);

   localparam int DEPTH = ARRAY_WIDTH + ARRAY_HEIGHT + 1;
   localparam int BW    = $clog2(ARRAY_WIDTH + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_STREAM, ST_DRAIN, ST_FINISH} state_t;

   state_t                 state_r, state_s;
   logic [BW-1:0]          beat_r;
   logic [CNT_WIDTH-1:0]   vec_cnt_r, num_vecs_r;
   logic [DEPTH-1:0]       vld_r;
   logic                   adv_s, in_fire_s, w_fire_s, last_beat_s, last_vec_s, empty_next_s;

   logic [WEIGHT_WIDTH-1:0] skew_out_s [ARRAY_WIDTH];
   logic [PSUM_WIDTH-1:0]   aligned_s  [ARRAY_HEIGHT];
   logic [INPUT_WIDTH-1:0]  pe_a_s     [ARRAY_HEIGHT][ARRAY_WIDTH];
   logic [WEIGHT_WIDTH-1:0] pe_w_s     [ARRAY_HEIGHT][ARRAY_WIDTH];
   logic [PSUM_WIDTH-1:0]   pe_p_s     [ARRAY_HEIGHT][ARRAY_WIDTH];

   assign w_ready = (state_r == ST_STREAM) && out_ready;

   // Handshake qualifiers; the whole datapath steps only when the consumer is ready.
   always_comb begin
      adv_s       = out_ready && ((state_r == ST_STREAM) || (state_r == ST_DRAIN));
      w_fire_s    = adv_s && (state_r == ST_STREAM) && w_valid;
      in_fire_s   = (state_r == ST_LOAD) && in_valid;
      last_beat_s = (beat_r == BW'(ARRAY_WIDTH - 1));
      last_vec_s  = (vec_cnt_r == (num_vecs_r - CNT_WIDTH'(1)));
      if (adv_s) begin
         empty_next_s = (vld_r == '0);
      end else begin
         empty_next_s = (vld_r == '0) && !out_valid;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_LOAD;
            else       state_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (in_fire_s && last_beat_s) state_s = (num_vecs_r == '0) ? ST_DRAIN : ST_STREAM;
            else                          state_s = ST_LOAD;
         end
         ST_STREAM: begin
            if (w_fire_s && last_vec_s) state_s = ST_DRAIN;
            else                        state_s = ST_STREAM;
         end
         ST_DRAIN: begin
            if (empty_next_s) state_s = ST_FINISH;
            else              state_s = ST_DRAIN;
         end
         ST_FINISH: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State, status outputs and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         in_ready   <= 1'b0;
         beat_r     <= '0;
         vec_cnt_r  <= '0;
         num_vecs_r <= '0;
      end else begin
         state_r  <= state_s;
         busy     <= (state_s != ST_IDLE);
         done     <= (state_s == ST_FINISH);
         in_ready <= (state_s == ST_LOAD);
         if ((state_r == ST_IDLE) && start) begin
            beat_r     <= '0;
            vec_cnt_r  <= '0;
            num_vecs_r <= cfg_num_vecs;
         end else begin
            if (in_fire_s) beat_r    <= beat_r + BW'(1);
            if (w_fire_s)  vec_cnt_r <= vec_cnt_r + CNT_WIDTH'(1);
         end
      end
   end

   // Valid tags travel alongside the data; bubbles enter as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv_s) begin
         vld_r     <= {vld_r[DEPTH-2:0], w_fire_s};
         out_valid <= vld_r[DEPTH-1];
         for (int r = 0; r < ARRAY_HEIGHT; r++) out_data[r*PSUM_WIDTH +: PSUM_WIDTH] <= aligned_s[r];
      end else begin
         vld_r     <= vld_r;
         out_valid <= out_valid;
         out_data  <= out_data;
      end
   end

   // Column c of the weight vector is delayed c extra cycles so it meets its psum wavefront.
   for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_skew
      logic [WEIGHT_WIDTH-1:0] sk_r [c+1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i <= c; i++) sk_r[i] <= '0;
         end else if (adv_s) begin
            sk_r[0] <= w_fire_s ? w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
            for (int i = 1; i <= c; i++) sk_r[i] <= sk_r[i-1];
         end else begin
            for (int i = 0; i <= c; i++) sk_r[i] <= sk_r[i];
         end
      end
      assign skew_out_s[c] = sk_r[c];
   end

   // Row r finishes r cycles after row 0; pad it so all rows land together.
   for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_unskew
      logic [PSUM_WIDTH-1:0] us_r [ARRAY_HEIGHT-r];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < ARRAY_HEIGHT - r; i++) us_r[i] <= '0;
         end else if (adv_s) begin
            us_r[0] <= pe_p_s[r][ARRAY_WIDTH-1];
            for (int i = 1; i < ARRAY_HEIGHT - r; i++) us_r[i] <= us_r[i-1];
         end else begin
            for (int i = 0; i < ARRAY_HEIGHT - r; i++) us_r[i] <= us_r[i];
         end
      end
      assign aligned_s[r] = us_r[ARRAY_HEIGHT-r-1];
   end

   for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
         logic [INPUT_WIDTH-1:0]  a_in_s;
         logic [WEIGHT_WIDTH-1:0] w_in_s;
         logic [PSUM_WIDTH-1:0]   p_in_s;
         // LOAD beats enter at the last column and shift left, so beat k ends in column k.
         if (c == ARRAY_WIDTH - 1) begin : g_a_edge
            assign a_in_s = in_data[r*INPUT_WIDTH +: INPUT_WIDTH];
         end else begin : g_a_chain
            assign a_in_s = pe_a_s[r][c+1];
         end
         if (r == 0) begin : g_w_edge
            assign w_in_s = skew_out_s[c];
         end else begin : g_w_chain
            assign w_in_s = pe_w_s[r-1][c];
         end
         if (c == 0) begin : g_p_edge
            assign p_in_s = '0;
         end else begin : g_p_chain
            assign p_in_s = pe_p_s[r][c-1];
         end
         pe_is #(
            .INPUT_WIDTH  (INPUT_WIDTH),
            .WEIGHT_WIDTH (WEIGHT_WIDTH),
            .PSUM_WIDTH   (PSUM_WIDTH)
         ) u_pe (
            .clk        (clk),
            .rst_n      (rst_n),
            .input_en   (in_fire_s),
            .input_in   (a_in_s),
            .input_out  (pe_a_s[r][c]),
            .process_en (adv_s),
            .weight_in  (w_in_s),
            .psum_in    (p_in_s),
            .weight_out (pe_w_s[r][c]),
            .psum_out   (pe_p_s[r][c])
         );
      end
   end

endmodule

// File: tb/tb_systolic_array_is_seq.sv
// Directed bench for systolic_array_is_seq: a 2x2 instance for the hand-worked case,
// a default 4x4 instance against a behavioural matrix-vector model.

module tb_systolic_array_is_seq;

   localparam int H = 4;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          start, in_valid, in_ready, w_valid, w_ready, out_valid, out_ready, busy, done;
   logic [15:0]   cfg_num_vecs;
   logic [63:0]   in_data, w_data;
   logic [127:0]  out_data;

   logic          start2, in_valid2, in_ready2, w_valid2, w_ready2, out_valid2, out_ready2, busy2, done2;
   logic [15:0]   cfg_num_vecs2;
   logic [31:0]   in_data2, w_data2;
   logic [63:0]   out_data2;

   systolic_array_is_seq u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_vecs(cfg_num_vecs),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   systolic_array_is_seq #(.ARRAY_HEIGHT(2), .ARRAY_WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .cfg_num_vecs(cfg_num_vecs2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .w_valid(w_valid2), .w_ready(w_ready2), .w_data(w_data2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .busy(busy2), .done(done2)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic [127:0]  exp_q [$];
   int            acc_q [$];
   logic signed [15:0] am [H][W];
   bit            lat_chk, hold_pend, fired_w, fix_en;
   logic [127:0]  hold_data, fix_exp;
   logic [63:0]   fix_w;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model(input logic [63:0] w);
      logic [127:0]       y;
      logic signed [31:0] acc;
      logic signed [15:0] ws;
      y = '0;
      for (int r = 0; r < H; r++) begin
         acc = 32'sd0;
         for (int c = 0; c < W; c++) begin
            ws  = w[c*16 +: 16];
            acc = acc + am[r][c] * ws;
         end
         y[r*32 +: 32] = acc;
      end
      return y;
   endfunction

   // Inputs are already driven; observe this cycle's transfers, then cross one posedge.
   task automatic tick();
      logic [127:0] e;
      int           c0;
      #1;
      if (hold_pend) check("stall_hold", out_data, hold_data);
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (!out_ready) check("wready_drop", 128'(w_ready), 128'd0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 128'(out_valid), 128'd0);
         end else begin
            e  = exp_q.pop_front();
            c0 = acc_q.pop_front();
            check("out_data", out_data, e);
            // accept seen before edge t, result seen after edge t+W+H+1
            if (lat_chk) check("latency", 128'(cyc - c0), 128'(W + H + 2));
         end
      end
      fired_w = w_valid && w_ready;
      if (fired_w) begin
         exp_q.push_back(fix_en ? fix_exp : model(w_data));
         acc_q.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic begin_run(input logic [15:0] nv);
      start        = 1'b1;
      cfg_num_vecs = nv;
      tick();
      start = 1'b0;
      check("busy_after_start", 128'(busy), 128'd1);
      check("in_ready_after_start", 128'(in_ready), 128'd1);
   endtask

   task automatic set_a(input int seed);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            am[r][c] = 16'(seed * (r + 1) - 700 * c + 13 * r);
   endtask

   task automatic load();
      in_valid = 1'b1;
      for (int k = 0; k < W; k++) begin
         for (int r = 0; r < H; r++) in_data[r*16 +: 16] = am[r][k];
         check("load_in_ready", 128'(in_ready), 128'd1);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic stream(input int n, input int gap, input int stall);
      int sent  = 0;
      int guard = 0;
      while ((sent < n || exp_q.size() != 0) && guard < 3000) begin
         w_valid   = (sent < n) && ($urandom_range(99) >= gap);
         w_data    = fix_en ? fix_w : {$urandom, $urandom};
         out_ready = ($urandom_range(99) >= stall);
         tick();
         if (fired_w) sent++;
         guard++;
      end
      w_valid   = 1'b0;
      out_ready = 1'b1;
      check("stream_outstanding", 128'((n - sent) + exp_q.size()), 128'd0);
      check("done_pulse", 128'(done), 128'd1);
      tick();
      check("done_low", 128'(done), 128'd0);
      check("busy_low", 128'(busy), 128'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0; cfg_num_vecs = 16'd0; in_valid = 1'b0; in_data = 64'd0;
      w_valid = 1'b0; w_data = 64'd0; out_ready = 1'b1;
      start2 = 1'b0; cfg_num_vecs2 = 16'd0; in_valid2 = 1'b0; in_data2 = 32'd0;
      w_valid2 = 1'b0; w_data2 = 32'd0; out_ready2 = 1'b1;
      lat_chk = 1'b0; hold_pend = 1'b0; fix_en = 1'b0; fix_w = 64'd0; fix_exp = 128'd0;
      hold_data = 128'd0; fired_w = 1'b0;

      #12;
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_w_ready", 128'(w_ready), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 2x2: A=[[1,2],[3,4]], w=[5,6] -> y=[17,39]
      start2 = 1'b1; cfg_num_vecs2 = 16'd1;
      tick();
      start2 = 1'b0;
      in_valid2 = 1'b1; in_data2 = {16'd3, 16'd1};
      check("x2_in_ready", 128'(in_ready2), 128'd1);
      tick();
      in_data2 = {16'd4, 16'd2};
      tick();
      in_valid2 = 1'b0;
      w_valid2 = 1'b1; w_data2 = {16'd6, 16'd5};
      check("x2_w_ready", 128'(w_ready2), 128'd1);
      tick();
      w_valid2 = 1'b0;
      repeat (4) tick();
      check("x2_not_yet", 128'(out_valid2), 128'd0);
      tick();
      check("x2_valid", 128'(out_valid2), 128'd1);
      check("x2_data", 128'(out_data2), 128'({32'd39, 32'd17}));
      tick();
      check("x2_done", 128'(done2), 128'd1);
      check("x2_valid_gone", 128'(out_valid2), 128'd0);
      tick();
      check("x2_idle", 128'(busy2), 128'd0);

      // 8 back-to-back vectors, fixed latency
      set_a(1234);
      begin_run(16'd8);
      load();
      lat_chk = 1'b1;
      stream(8, 0, 0);
      lat_chk = 1'b0;

      // random gaps and 50% backpressure, A replaced
      set_a(-4321);
      begin_run(16'd12);
      load();
      stream(12, 30, 50);

      // signed extremes wrap to zero
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) am[r][c] = 16'sh8000;
      fix_en = 1'b1; fix_w = {4{16'h8000}}; fix_exp = 128'd0;
      begin_run(16'd1);
      load();
      stream(1, 0, 0);
      fix_en = 1'b0;

      // zero vectors: done straight after the load
      set_a(77);
      begin_run(16'd0);
      load();
      check("zero_no_done_yet", 128'(done), 128'd0);
      tick();
      check("zero_done", 128'(done), 128'd1);
      check("zero_no_out", 128'(out_valid), 128'd0);
      tick();
      check("zero_idle", 128'(busy), 128'd0);

      // reset with three results in flight
      set_a(555);
      begin_run(16'd10);
      load();
      w_valid = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         w_data = {$urandom, $urandom};
         tick();
      end
      w_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 128'(out_valid), 128'd0);
      check("midrst_out_data", out_data, 128'd0);
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_done", 128'(done), 128'd0);
      check("midrst_w_ready", 128'(w_ready), 128'd0);
      check("midrst_in_ready", 128'(in_ready), 128'd0);
      exp_q.delete();
      acc_q.delete();
      hold_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         tick();
         check("postrst_no_done", 128'(done), 128'd0);
      end

      // fresh run after reset
      set_a(9876);
      begin_run(16'd4);
      load();
      lat_chk = 1'b1;
      stream(4, 0, 0);
      lat_chk = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
